// File: rtl/inst_fetch_ctrl.sv
// Instruction-fetch controller: walks the PC through the program image into a
// 2-entry fetch buffer presented to decode, flushing on branch/jump redirects.
module inst_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter logic [31:0] END_ADDR = 32'd148
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [31:0] inst_add,
  input  logic [31:0] inst_code,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  input  logic        out_ready,
  output logic        busy,
  output logic        done,
  output logic        misalign_err
);

  // IDLE: wait for start | RUN: fetching | DONE: image exhausted | ERR: misaligned redirect
  typedef enum logic [1:0] {IDLE, RUN, DONE, ERR} state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] e0_inst_q, e0_pc_q, e1_inst_q, e1_pc_q;
  logic [1:0]  count_q;
  logic        valid_q, busy_q, done_q, err_q;

  logic        pop, at_end, fetch, redir_ok;
  logic [1:0]  count_ap, count_d;

  assign pop      = valid_q && out_ready;
  assign at_end   = (pc_q == END_ADDR);
  assign fetch    = !redirect_valid && !at_end && ((count_q < 2'd2) || pop);
  assign redir_ok = (redirect_pc[1:0] == 2'b00);
  assign count_ap = count_q - {1'b0, pop};
  assign count_d  = count_ap + {1'b0, fetch};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      e0_inst_q <= 32'd0;
      e0_pc_q   <= 32'd0;
      e1_inst_q <= 32'd0;
      e1_pc_q   <= 32'd0;
      count_q   <= 2'd0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            pc_q    <= RESET_PC;
            count_q <= 2'd0;
            valid_q <= 1'b0;
          end
        end
        RUN, DONE: begin
          if (redirect_valid) begin
            // Flush drops anything pushed or popped this cycle.
            count_q <= 2'd0;
            valid_q <= 1'b0;
            if (!redir_ok) begin
              state_q <= ERR;
              err_q   <= 1'b1;
              busy_q  <= 1'b0;
              done_q  <= 1'b0;
            end else begin
              pc_q <= redirect_pc;
              if (redirect_pc == END_ADDR) begin
                state_q <= DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                state_q <= RUN;
                busy_q  <= 1'b1;
                done_q  <= 1'b0;
              end
            end
          end else if (state_q == RUN) begin
            if (pop && (count_q == 2'd2)) begin
              e0_inst_q <= e1_inst_q;
              e0_pc_q   <= e1_pc_q;
            end
            // New word lands in the first slot free after this cycle's pop.
            if (fetch) begin
              if (count_ap == 2'd0) begin
                e0_inst_q <= inst_code;
                e0_pc_q   <= pc_q;
              end else begin
                e1_inst_q <= inst_code;
                e1_pc_q   <= pc_q;
              end
              pc_q <= pc_q + 32'd4;
            end
            count_q <= count_d;
            valid_q <= (count_d != 2'd0);
            if (at_end && (count_d == 2'd0)) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        ERR: begin
        end
      endcase
    end
  end

  assign inst_add     = pc_q;
  assign out_valid    = valid_q;
  assign out_inst     = e0_inst_q;
  assign out_pc       = e0_pc_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign misalign_err = err_q;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Self-checking bench for inst_fetch_ctrl: scoreboard of expected {pc, inst}
// words pushed as stimulus is applied and popped as decode accepts them.
module tb_inst_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, redirect_valid, out_ready;
  logic [31:0] inst_add, inst_code, redirect_pc, out_inst, out_pc;
  logic        out_valid, busy, done, misalign_err;

  int errors = 0;
  int checks = 0;
  logic [63:0] sb[$];
  logic [63:0] exp_w;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    case (a)
      32'd0:   return 32'h00940333;
      32'd4:   return 32'h413903b3;
      default: return (a * 32'h9E3779B1) ^ 32'h5A5A0013;
    endcase
  endfunction

  assign inst_code = mem(inst_add);

  inst_fetch_ctrl dut (
    .clk(clk), .reset(reset), .start(start),
    .inst_add(inst_add), .inst_code(inst_code),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc),
    .out_ready(out_ready), .busy(busy), .done(done), .misalign_err(misalign_err)
  );

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; start = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0; out_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
  endtask

  task automatic do_start(input logic rdy);
    start = 1'b1; out_ready = rdy;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (inst_add !== 32'd0) begin errors++; $display("FAIL reset_inst_add: got %h want 00000000", inst_add); end
    checks++;
    if ({out_valid, busy, done, misalign_err} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got v/b/d/e=%b want 0000", {out_valid, busy, done, misalign_err});
    end
    checks++;
    if (out_inst !== 32'd0 || out_pc !== 32'd0) begin
      errors++; $display("FAIL reset_head: got inst=%h pc=%h want 0/0", out_inst, out_pc);
    end
  endtask

  task automatic test_stream();
    do_reset();
    for (int p = 0; p < 148; p += 4) sb.push_back({32'(p), mem(32'(p))});
    do_start(1'b1);
    checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0 || inst_add !== 32'd0) begin
      errors++; $display("FAIL start_state: got busy=%b valid=%b add=%h want 1 0 00000000", busy, out_valid, inst_add);
    end
    for (int i = 0; i < 37; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1) begin
        errors++; $display("FAIL stream_valid: cycle %0d got valid=%b want 1", i, out_valid);
      end else begin
        exp_w = sb.pop_front();
        if ({out_pc, out_inst} !== exp_w) begin
          errors++; $display("FAIL stream_data: got pc=%h inst=%h want pc=%h inst=%h", out_pc, out_inst, exp_w[63:32], exp_w[31:0]);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || inst_add !== 32'd148) begin
      errors++; $display("FAIL stream_done: got done=%b busy=%b valid=%b add=%h want 1 0 0 00000094", done, busy, out_valid, inst_add);
    end
  endtask

  task automatic test_backpressure();
    int n;
    do_reset();
    do_start(1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (out_pc !== 32'd0) begin errors++; $display("FAIL bp_hold_pc: got %h want 00000000", out_pc); end
    end
    checks++;
    if (inst_add !== 32'd8 || out_valid !== 1'b1) begin
      errors++; $display("FAIL bp_freeze: got add=%h valid=%b want 00000008 1", inst_add, out_valid);
    end
    for (int p = 0; p <= 16; p += 4) sb.push_back({32'(p), mem(32'(p))});
    out_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 20 && sb.size() > 0; c++) begin
      if (out_valid === 1'b1) begin
        exp_w = sb.pop_front();
        checks++;
        if ({out_pc, out_inst} !== exp_w) begin
          errors++; $display("FAIL bp_resume: got pc=%h want pc=%h", out_pc, exp_w[63:32]);
        end
      end
      n++;
      @(negedge clk);
    end
    checks++;
    if (n !== 5) begin errors++; $display("FAIL bp_throughput: got %0d cycles want 5", n); end
  endtask

  task automatic test_redirect();
    bit found = 0;
    do_reset();
    for (int p = 0; p <= 20; p += 4) sb.push_back({32'(p), mem(32'(p))});
    do_start(1'b1);
    for (int c = 0; c < 20 && sb.size() > 0; c++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        checks++;
        if ({out_pc, out_inst} !== sb[0]) begin
          errors++; $display("FAIL rd_prefix: got pc=%h want pc=%h", out_pc, sb[0][63:32]);
        end
        if (sb[0][63:32] == 32'd20) begin out_ready = 1'b0; found = 1; break; end
        void'(sb.pop_front());
      end
    end
    checks++;
    if (!found) begin errors++; $display("FAIL rd_setup: got no head at pc 20 want head 00000014"); end
    @(negedge clk);
    checks++;
    if (out_pc !== 32'd20 || out_valid !== 1'b1 || inst_add !== 32'd28) begin
      errors++; $display("FAIL rd_full: got pc=%h valid=%b add=%h want 00000014 1 0000001c", out_pc, out_valid, inst_add);
    end
    redirect_valid = 1'b1; redirect_pc = 32'd116;
    @(negedge clk);
    redirect_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || inst_add !== 32'd116) begin
      errors++; $display("FAIL rd_flush: got valid=%b add=%h want 0 00000074", out_valid, inst_add);
    end
    sb.delete();
    for (int p = 116; p <= 124; p += 4) sb.push_back({32'(p), mem(32'(p))});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      exp_w = sb.pop_front();
      checks++;
      if (out_valid !== 1'b1 || {out_pc, out_inst} !== exp_w) begin
        errors++; $display("FAIL rd_target: got valid=%b pc=%h want 1 pc=%h", out_valid, out_pc, exp_w[63:32]);
      end
    end
  endtask

  task automatic test_misalign();
    do_reset();
    do_start(1'b1);
    repeat (3) @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h6A;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++;
    if (misalign_err !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || inst_add !== 32'd12) begin
      errors++; $display("FAIL mis_enter: got err=%b valid=%b busy=%b done=%b add=%h want 1 0 0 0 0000000c",
                         misalign_err, out_valid, busy, done, inst_add);
    end
    start = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'd40;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (misalign_err !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || inst_add !== 32'd12) begin
        errors++; $display("FAIL mis_absorb: got err=%b valid=%b busy=%b add=%h want 1 0 0 0000000c",
                           misalign_err, out_valid, busy, inst_add);
      end
    end
    start = 1'b0; redirect_valid = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if (misalign_err !== 1'b0) begin errors++; $display("FAIL mis_reset: got err=%b want 0", misalign_err); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_done_redirect();
    int acc = 0;
    do_reset();
    do_start(1'b1);
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (done === 1'b1) break;
    end
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL dn_reach: got done=%b want 1", done); end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || inst_add !== 32'd148) begin
      errors++; $display("FAIL dn_start_ignored: got done=%b busy=%b valid=%b add=%h want 1 0 0 00000094", done, busy, out_valid, inst_add);
    end
    redirect_valid = 1'b1; redirect_pc = 32'd40;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || out_valid !== 1'b0 || inst_add !== 32'd40) begin
      errors++; $display("FAIL dn_redirect: got busy=%b done=%b valid=%b add=%h want 1 0 0 00000028", busy, done, out_valid, inst_add);
    end
    sb.push_back({32'd40, mem(32'd40)});
    sb.push_back({32'd44, mem(32'd44)});
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      exp_w = sb.pop_front();
      checks++;
      if (out_valid !== 1'b1 || {out_pc, out_inst} !== exp_w) begin
        errors++; $display("FAIL dn_resume: got valid=%b pc=%h want 1 pc=%h", out_valid, out_pc, exp_w[63:32]);
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) acc++;
    end
    redirect_valid = 1'b1; redirect_pc = 32'd80;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || inst_add !== 32'd80) begin
      errors++; $display("FAIL pr_flush: got valid=%b add=%h want 0 00000050", out_valid, inst_add);
    end
    sb.push_back({32'd80, mem(32'd80)});
    @(negedge clk);
    exp_w = sb.pop_front();
    checks++;
    if (out_valid !== 1'b1 || {out_pc, out_inst} !== exp_w) begin
      errors++; $display("FAIL pr_target: got valid=%b pc=%h want 1 pc=%h", out_valid, out_pc, exp_w[63:32]);
    end
    if (out_valid === 1'b1) acc++;
    checks++;
    if (acc !== 3) begin errors++; $display("FAIL pr_accept_count: got %0d want 3", acc); end
    redirect_valid = 1'b1; redirect_pc = 32'd148;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || inst_add !== 32'd148) begin
      errors++; $display("FAIL rd_to_end: got done=%b busy=%b valid=%b add=%h want 1 0 0 00000094", done, busy, out_valid, inst_add);
    end
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || inst_add !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_redirect: got busy=%b add=%h want 1 fffffffc", busy, inst_add);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'hFFFF_FFFC || out_inst !== mem(32'hFFFF_FFFC) || inst_add !== 32'd0) begin
      errors++; $display("FAIL wrap_pc: got valid=%b pc=%h add=%h want 1 fffffffc 00000000", out_valid, out_pc, inst_add);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    do_start(1'b1);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (inst_add !== 32'd0 || out_pc !== 32'd0 || out_inst !== 32'd0) begin
      errors++; $display("FAIL async_data: got add=%h pc=%h inst=%h want 0 0 0", inst_add, out_pc, out_inst);
    end
    checks++;
    if ({out_valid, busy, done, misalign_err} !== 4'b0000) begin
      errors++; $display("FAIL async_flags: got v/b/d/e=%b want 0000", {out_valid, busy, done, misalign_err});
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || inst_add !== 32'd0) begin
      errors++; $display("FAIL async_idle: got busy=%b valid=%b add=%h want 0 0 00000000", busy, out_valid, inst_add);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0; out_ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_misalign();
    test_done_redirect();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
